// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for one shared tristate wire. It produces registered
// one-hot buffer enables with a bounded burst and an all-released turnaround gap.
module tristate_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  output logic [N_REQ-1:0]         en_o,
  output logic [$clog2(N_REQ)-1:0] gnt_id_o,
  output logic                     busy_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURNAROUND + 1);
  localparam logic [IW:0]   NREQ_W  = (IW+1)'(N_REQ);
  localparam logic [BW-1:0] BURST_W = BW'(MAX_BURST);
  localparam logic [TW-1:0] TURN_W  = TW'(TURNAROUND);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  en_q, en_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [TW-1:0]     turn_q, turn_d;

  // Candidate index at each search offset from ptr, wrapped modulo N_REQ.
  logic [IW-1:0] rot_idx [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_rot
    logic [IW:0] sum;
    assign sum        = {1'b0, ptr_q} + (IW+1)'(g);
    assign rot_idx[g] = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
  end

  logic [IW-1:0] win_c;
  logic          any_req;
  assign any_req = |req_i;

  // Scan from the far end so the smallest offset from ptr wins.
  always_comb begin
    win_c = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_i[rot_idx[i]]) win_c = rot_idx[i];
  end

  logic [IW:0]   gnt_inc;
  logic [IW-1:0] ptr_rel;
  assign gnt_inc = {1'b0, gnt_q} + (IW+1)'(1);
  assign ptr_rel = (gnt_inc == NREQ_W) ? '0 : IW'(gnt_inc);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    turn_d  = turn_q;
    unique case (state_q)
      S_IDLE: begin
        en_d   = '0;
        busy_d = 1'b0;
        if (any_req) begin
          state_d     = S_OWN;
          en_d[win_c] = 1'b1;
          gnt_d       = win_c;
          busy_d      = 1'b1;
          burst_d     = BW'(1);
        end
      end
      S_OWN: begin
        if (!req_i[gnt_q] || burst_q == BURST_W) begin
          state_d = S_TURN;
          en_d    = '0;
          busy_d  = 1'b0;
          turn_d  = TW'(1);
          ptr_d   = ptr_rel;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      S_TURN: begin
        if (turn_q == TURN_W) begin
          if (any_req) begin
            state_d     = S_OWN;
            en_d        = '0;
            en_d[win_c] = 1'b1;
            gnt_d       = win_c;
            busy_d      = 1'b1;
            burst_d     = BW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      burst_q <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      turn_q  <= turn_d;
    end
  end

  assign en_o     = en_q;
  assign gnt_id_o = gnt_q;
  assign busy_o   = busy_q;
endmodule
